// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. It accepts one word
//   read or write at a time and performs the access into an internal word
//   array LATENCY cycles after the request is accepted. Completion is a
//   one-cycle mem_ready pulse. Misaligned, out-of-range or simultaneous
//   read+write requests complete with mem_error set and leave storage
//   and data_out untouched.
//
// Parameters
//   DEPTH   : number of 32-bit words stored
//   ADDR_W  : word-index width, log2(DEPTH)
//   LATENCY : cycles from the accept edge to the access edge, 1..15
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-low reset
//   mem_read     : read request
//   mem_write    : write request
//   data_address : byte address; the word index is data_address[ADDR_W+1:2]
//   data_in      : write data
//   data_out     : registered read data, holds the last successful read
//   mem_ready    : one-cycle completion pulse
//   mem_error    : error status of the completing request (valid with mem_ready)
//   mem_busy     : high whenever a transaction is in flight or completing

module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_error,
  output logic        mem_busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HI_LSB = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Word storage; never reset so contents survive a reset pulse.
  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;
  logic               w_do_access;

  // Captured transaction
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_is_write;
  logic               r_err;

  // Registered outputs
  logic [DATA_W-1:0]  r_data_out;
  logic               r_mem_ready;
  logic               r_mem_error;
  logic               r_mem_busy;

  // Request classification, evaluated against the live request inputs
  logic               w_req;
  logic               w_misaligned;
  logic               w_out_of_range;
  logic               w_illegal;
  logic               w_req_err;
  logic               w_mem_we;
  logic               w_rd_load;

  assign w_req          = mem_read | mem_write;
  assign w_misaligned   = |data_address[1:0];
  assign w_out_of_range = |data_address[31:HI_LSB];
  assign w_illegal      = mem_read & mem_write;
  assign w_req_err      = w_misaligned | w_out_of_range | w_illegal;

  // Errored transactions complete normally but never touch storage or data_out.
  assign w_mem_we  = w_do_access &  r_is_write & ~r_err;
  assign w_rd_load = w_do_access & ~r_is_write & ~r_err;

  // Next-state logic: accept in IDLE, count down in BUSY, pulse in DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_do_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_accept    = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          w_do_access = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_mem_ready <= 1'b0;
      r_mem_error <= 1'b0;
      r_mem_busy  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_ready <= (w_state_nxt == S_DONE);
      r_mem_error <= (w_state_nxt == S_DONE) ? r_err : 1'b0;
      r_mem_busy  <= (w_state_nxt != S_IDLE);
      if (w_rd_load) begin
        r_data_out <= r_mem[r_addr];
      end
    end
  end

  // Transaction capture at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= data_address[HI_LSB-1:2];
      r_wdata    <= data_in;
      r_is_write <= mem_write;
      r_err      <= w_req_err;
    end
  end

  // Storage write port; gated by the FSM, so a reset before the access edge drops the write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign data_out  = r_data_out;
  assign mem_ready = r_mem_ready;
  assign mem_error = r_mem_error;
  assign mem_busy  = r_mem_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: three instances with
// LATENCY 2, 1 and 15, each driven through its own request signals.

module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd_q   [3];
  logic        wr_q   [3];
  logic [31:0] addr_q [3];
  logic [31:0] din_q  [3];
  logic [31:0] dout_w [3];
  logic        rdy_w  [3];
  logic        err_w  [3];
  logic        busy_w [3];

  int n_tests;
  int n_fail;

  data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .mem_read(rd_q[0]), .mem_write(wr_q[0]),
    .data_address(addr_q[0]), .data_in(din_q[0]), .data_out(dout_w[0]),
    .mem_ready(rdy_w[0]), .mem_error(err_w[0]), .mem_busy(busy_w[0])
  );

  data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .mem_read(rd_q[1]), .mem_write(wr_q[1]),
    .data_address(addr_q[1]), .data_in(din_q[1]), .data_out(dout_w[1]),
    .mem_ready(rdy_w[1]), .mem_error(err_w[1]), .mem_busy(busy_w[1])
  );

  data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst(rst), .mem_read(rd_q[2]), .mem_write(wr_q[2]),
    .data_address(addr_q[2]), .data_in(din_q[2]), .data_out(dout_w[2]),
    .mem_ready(rdy_w[2]), .mem_error(err_w[2]), .mem_busy(busy_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one transaction on instance k and wait (bounded) for mem_ready.
  // lat counts falling edges after the accept edge up to the ready sample.
  task automatic txn(input int k, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] q, output logic e, output int lat);
    @(negedge clk);
    rd_q[k] = rd; wr_q[k] = wr; addr_q[k] = a; din_q[k] = d;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy_w[k] && lat < 40);
    q = dout_w[k];
    e = err_w[k];
    rd_q[k] = 1'b0; wr_q[k] = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] obs;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_q[k] = 1'b0; wr_q[k] = 1'b0; addr_q[k] = '0; din_q[k] = '0;
    end
    repeat (3) @(negedge clk);
    obs = {busy_w[0], rdy_w[0], err_w[0], dout_w[0]};
    n_tests++;
    if (obs !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, 35'h0);
    end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      obs = {busy_w[0], rdy_w[0], err_w[0], dout_w[0]};
      n_tests++;
      if (obs !== 35'h0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", c, obs, 35'h0);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] q; logic e; int lat;
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, q, e, lat);
    n_tests++;
    if ({lat, e, q} !== {32'd3, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL wr_0x10: got lat=%0d err=%b dout=%h expected lat=3 err=0 dout=0", lat, e, q);
    end
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, q, e, lat);
    n_tests++;
    if ({lat, e, q} !== {32'd3, 1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_0x10: got lat=%0d err=%b dout=%h expected lat=3 err=0 dout=deadbeef", lat, e, q);
    end
    // Highest legal word
    txn(0, 1'b0, 1'b1, 32'h3FC, 32'h5A5A0001, q, e, lat);
    txn(0, 1'b1, 1'b0, 32'h3FC, 32'h0, q, e, lat);
    n_tests++;
    if ({e, q} !== {1'b0, 32'h5A5A0001}) begin
      n_fail++;
      $display("FAIL rd_0x3fc: got err=%b dout=%h expected err=0 dout=5a5a0001", e, q);
    end
  endtask

  task automatic test_errors();
    logic [31:0] q; logic e; int lat;
    txn(0, 1'b0, 1'b1, 32'h12, 32'h11111111, q, e, lat);
    n_tests++;
    if ({lat, e, q} !== {32'd3, 1'b1, 32'h5A5A0001}) begin
      n_fail++;
      $display("FAIL wr_misaligned: got lat=%0d err=%b dout=%h expected lat=3 err=1 dout=5a5a0001", lat, e, q);
    end
    txn(0, 1'b0, 1'b1, 32'h400, 32'h22222222, q, e, lat);
    n_tests++;
    if ({e, q} !== {1'b1, 32'h5A5A0001}) begin
      n_fail++;
      $display("FAIL wr_out_of_range: got err=%b dout=%h expected err=1 dout=5a5a0001", e, q);
    end
    txn(0, 1'b1, 1'b0, 32'h11, 32'h0, q, e, lat);
    n_tests++;
    if ({e, q} !== {1'b1, 32'h5A5A0001}) begin
      n_fail++;
      $display("FAIL rd_misaligned: got err=%b dout=%h expected err=1 dout=5a5a0001", e, q);
    end
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, q, e, lat);
    n_tests++;
    if ({e, q} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_after_err: got err=%b dout=%h expected err=0 dout=deadbeef", e, q);
    end
    // The misaligned write aimed at word 4 (0x10) must not have landed there.
    n_tests++;
    if (dout_w[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word4_intact: got %h expected deadbeef", dout_w[0]);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] q; logic e; int lat;
    txn(0, 1'b0, 1'b1, 32'h20, 32'h12345678, q, e, lat);
    txn(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, q, e, lat);
    n_tests++;
    if ({e, q} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_wr_both: got err=%b dout=%h expected err=1 dout=deadbeef", e, q);
    end
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, q, e, lat);
    n_tests++;
    if ({e, q} !== {1'b0, 32'h12345678}) begin
      n_fail++;
      $display("FAIL rd_0x20_after_illegal: got err=%b dout=%h expected err=0 dout=12345678", e, q);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] q; logic e; int lat;
    txn(0, 1'b0, 1'b1, 32'h30, 32'h0000AAAA, q, e, lat);
    @(negedge clk);
    wr_q[0] = 1'b1; addr_q[0] = 32'h30; din_q[0] = 32'hCAFEF00D;
    @(posedge clk);            // accept edge
    @(posedge clk);            // one cycle later, before the access edge
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({busy_w[0], rdy_w[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_on_reset: got busy=%b ready=%b expected busy=0 ready=0", busy_w[0], rdy_w[0]);
    end
    wr_q[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_tests++;
    if (dout_w[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL dout_after_reset: got %h expected 00000000", dout_w[0]);
    end
    txn(0, 1'b1, 1'b0, 32'h30, 32'h0, q, e, lat);
    n_tests++;
    if ({lat, e, q} !== {32'd3, 1'b0, 32'h0000AAAA}) begin
      n_fail++;
      $display("FAIL rd_0x30_after_abort: got lat=%0d err=%b dout=%h expected lat=3 err=0 dout=0000aaaa", lat, e, q);
    end
  endtask

  // Hold a write request high across mem_ready; the second accept must
  // follow a single IDLE cycle with mem_busy low.
  task automatic test_back_to_back(input int k, input int exp_lat);
    int lat;
    @(negedge clk);
    wr_q[k] = 1'b1; rd_q[k] = 1'b0;
    addr_q[k] = 32'h40; din_q[k] = 32'hB0B00000 | 32'(k);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy_w[k] && lat < 40);
    n_tests++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL b2b_first_lat[%0d]: got %0d expected %0d", k, lat, exp_lat);
    end
    @(negedge clk);
    n_tests++;
    if ({busy_w[k], rdy_w[k]} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_idle_gap[%0d]: got busy=%b ready=%b expected busy=0 ready=0", k, busy_w[k], rdy_w[k]);
    end
    @(negedge clk);
    n_tests++;
    if (busy_w[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reaccept[%0d]: got busy=%b expected 1", k, busy_w[k]);
    end
    lat = 1;
    while (!rdy_w[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if ({lat, err_w[k]} !== {exp_lat, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second_lat[%0d]: got lat=%0d err=%b expected lat=%0d err=0", k, lat, err_w[k], exp_lat);
    end
    wr_q[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] q; logic e; int lat;
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_errors();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back(0, 3);
    test_back_to_back(1, 2);
    test_back_to_back(2, 16);
    txn(0, 1'b1, 1'b0, 32'h40, 32'h0, q, e, lat);
    n_tests++;
    if ({e, q} !== {1'b0, 32'hB0B00000}) begin
      n_fail++;
      $display("FAIL rd_0x40_after_b2b: got err=%b dout=%h expected err=0 dout=b0b00000", e, q);
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data port.
- Accepts word read/write requests on data_address/data_in with mem_read/mem_write.
- Performs the access into an internal word array after a configurable latency.
- Returns read data on data_out with a one-cycle mem_ready pulse.
- Flags misaligned or out-of-range requests on mem_error without touching storage.
- Used in place of the ideal zero-latency data memory when the core is upgraded to stall on memory.

Parameters:
- DEPTH, 256, number of 32-bit words stored.
- ADDR_W, 8, log2(DEPTH); word-index width.
- LATENCY, 2, cycles from accept edge to access edge; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- mem_read  input  1  read request.
- mem_write  input  1  write request.
- data_address  input  32  byte address; word index = data_address[ADDR_W+1:2].
- data_in  input  32  write data.
- data_out  output  32  registered read data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_error  output  1  error status of the completing request; valid while mem_ready=1.
- mem_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE; mem_ready=0, mem_error=0, mem_busy=0, data_out=32'h0, latency counter=0. Storage is not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE, accept rule: on an edge with mem_read|mem_write=1, the block captures address, data, op and error, loads counter=LATENCY-1 and moves to BUSY.
- IDLE, no request: stays in IDLE.
- Error conditions, computed at accept:
  - data_address[1:0]!=0 (misaligned).
  - data_address[31:ADDR_W+2]!=0 (out of range).
  - mem_read=1 and mem_write=1 simultaneously (illegal).
- BUSY: counter decrements each edge while >0. On the edge where counter==0:
  - Access performed: write commits captured data, or read loads data_out from array.
  - Moves to DONE.
  - Errored request: no storage write and data_out unchanged.
- DONE: mem_ready=1 for exactly this cycle; mem_error=captured error. Next edge returns to IDLE, where mem_ready=0 and mem_error=0.
- Timing: accept at edge E0, access at edge E(LATENCY), mem_ready high in the cycle following E(LATENCY). Issue interval is LATENCY+2 cycles per request.
- data_out holds the last successful read value until the next successful read; writes do not alter it.
- mem_read/mem_write/data_* are ignored in BUSY and DONE.
- The initiator must drop its request during the mem_ready cycle. A request still high in IDLE is accepted again as a new transaction.
- Reset mid-operation: the transaction is aborted.
  - A write whose access edge has not occurred is not committed.
  - A write already committed remains.
- Read-after-write to the same word returns the new data, since accesses are strictly serialized.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, then release with no requests → data_out=0, mem_ready=0, mem_busy=0 for 10 cycles.
2. Write/read: write 32'hDEADBEEF to addr 32'h10, then read 32'h10 → each mem_ready appears 3 cycles after its accept edge (LATENCY=2); read data_out=32'hDEADBEEF; mem_error=0.
3. Misaligned/out of range:
   - write 32'h11111111 to 32'h12 → mem_error=1 at mem_ready.
   - write to 32'h400 → mem_error=1 at mem_ready.
   - subsequent read of 32'h10 still returns 32'hDEADBEEF; data_out unchanged by the error responses.
4. Simultaneous mem_read=mem_write=1 at 32'h20 → mem_error=1; word 0x20 retains its prior value (verified by a following legal read).
5. Reset mid-write: accept write 32'hCAFEF00D to 32'h30 (prior 32'h0000AAAA), assert rst one cycle after accept → after release, read 32'h30 returns 32'h0000AAAA; mem_busy=0 immediately on rst.
6. Back-to-back: request held high through mem_ready → second transaction accepted the IDLE cycle after DONE; mem_busy low for exactly that one cycle. Repeat with LATENCY=1 and LATENCY=15 → ready 2 and 16 cycles after accept respectively.
